// File: rtl/regfile_sb_if.sv
// Register-file port bundle: writeback, issue tracking, two operand reads and one debug read.
// The bench or pipeline drives the master side; the register file implements the slave side.
interface regfile_sb_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   logic          we;
   logic [AW-1:0] wa;
   logic [DW-1:0] wd;
   logic [AW-1:0] ra0;
   logic [AW-1:0] ra1;
   logic [AW-1:0] ra_dbg;
   logic [DW-1:0] rd0;
   logic [DW-1:0] rd1;
   logic [DW-1:0] rd_dbg;
   logic          issue_valid;
   logic [AW-1:0] issue_rd;
   logic          busy0;
   logic          busy1;
   logic          init_done;

   modport master (
      output we, wa, wd, ra0, ra1, ra_dbg, issue_valid, issue_rd,
      input  rd0, rd1, rd_dbg, busy0, busy1, init_done
   );

   modport slave (
      input  we, wa, wd, ra0, ra1, ra_dbg, issue_valid, issue_rd,
      output rd0, rd1, rd_dbg, busy0, busy1, init_done
   );
endinterface

// File: rtl/regfile_sb.sv
// Register file with pending-writer scoreboard; reads are combinational with write-through bypass.
// No backpressure: after the NREG-cycle zeroing sweep (init_done=0) every cycle accepts traffic.
module regfile_sb #(
   parameter int DW       = 32,
   parameter int AW       = 5,
   parameter int ZERO_REG = 1
) (
   input  logic         clk,
   input  logic         rst,
   regfile_sb_if.slave  bus
);
   localparam int NREG = 1 << AW;

   typedef enum logic {INIT, RUN} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic [NREG-1:0] pend_q, pend_d;
   logic [DW-1:0]   mem [NREG];
   logic            run;
   logic            wr_ok;
   logic            iss_ok;
   logic [AW-1:0]   ra  [3];
   logic [DW-1:0]   rdv [3];

   assign run    = (state_q == RUN);
   assign wr_ok  = run && bus.we && ((ZERO_REG == 0) || (bus.wa != '0));
   assign iss_ok = run && bus.issue_valid && ((ZERO_REG == 0) || (bus.issue_rd != '0));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= INIT;
         ptr_q   <= '0;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         INIT: begin
            ptr_d = ptr_q + AW'(1);
            if (&ptr_q) state_d = RUN;
         end
         RUN:     ptr_d = ptr_q;
         default: state_d = INIT;
      endcase
   end

   // Set is applied after clear so a new producer issued in the same cycle stays outstanding.
   always_comb begin
      pend_d = pend_q;
      if (wr_ok)  pend_d[bus.wa]       = 1'b0;
      if (iss_ok) pend_d[bus.issue_rd] = 1'b1;
   end

   // No reset on the array: contents are only zeroed by the INIT sweep.
   always_ff @(posedge clk) begin
      if (!run)
         mem[ptr_q] <= '0;
      else if (wr_ok)
         mem[bus.wa] <= bus.wd;
   end

   assign ra[0] = bus.ra0;
   assign ra[1] = bus.ra1;
   assign ra[2] = bus.ra_dbg;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         rdv[i] = '0;
         if (run && !((ZERO_REG != 0) && (ra[i] == '0)))
            rdv[i] = (wr_ok && (bus.wa == ra[i])) ? bus.wd : mem[ra[i]];
      end
   end

   assign bus.rd0    = rdv[0];
   assign bus.rd1    = rdv[1];
   assign bus.rd_dbg = rdv[2];

   assign bus.busy0     = run && pend_q[bus.ra0] && !(wr_ok && (bus.wa == bus.ra0));
   assign bus.busy1     = run && pend_q[bus.ra1] && !(wr_ok && (bus.wa == bus.ra1));
   assign bus.init_done = run;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: inputs change on the falling edge, outputs are sampled 1 time unit later.
module tb_regfile_sb;
   localparam int DW = 32;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;

   regfile_sb_if #(.DW(DW), .AW(AW)) bus ();

   regfile_sb #(.DW(DW), .AW(AW), .ZERO_REG(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Counts rising edges until init_done; whatever traffic is being driven is dropped on exit.
   task automatic wait_init(input string tag);
      int cyc = 0;
      while (cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 5) begin
            check({tag, "_mid_rd0"},  bus.rd0,       32'h0);
            check({tag, "_mid_busy"}, bus.busy0,     32'h0);
            check({tag, "_mid_done"}, bus.init_done, 32'h0);
         end
         if (bus.init_done) break;
      end
      bus.we          = 1'b0;
      bus.issue_valid = 1'b0;
      check({tag, "_cycles"}, cyc, 32);
   endtask

   initial begin
      rst             = 1'b1;
      bus.we          = 1'b0;
      bus.wa          = '0;
      bus.wd          = '0;
      bus.ra0         = '0;
      bus.ra1         = '0;
      bus.ra_dbg      = '0;
      bus.issue_valid = 1'b0;
      bus.issue_rd    = '0;
      repeat (3) step();
      check("rst_done", bus.init_done, 32'h0);
      check("rst_rd0",  bus.rd0,       32'h0);
      check("rst_busy", bus.busy1,     32'h0);

      // Writes and issues during INIT must be ignored.
      bus.we          = 1'b1;
      bus.wa          = 5'd4;
      bus.wd          = 32'hFFFF_FFFF;
      bus.ra0         = 5'd4;
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 5'd4;
      rst             = 1'b0;
      wait_init("init1");

      step(); #1;
      check("init_ent4_rd0",  bus.rd0,   32'h0);
      check("init_ent4_busy", bus.busy0, 32'h0);
      for (int a = 0; a < 32; a++) begin
         bus.ra_dbg = AW'(a);
         #1;
         check($sformatf("zero_dbg%0d", a), bus.rd_dbg, 32'h0);
      end

      // Write-through bypass, then array read.
      step();
      bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'hDEAD_BEEF; bus.ra0 = 5'd5;
      #1; check("bypass_rd0", bus.rd0, 32'hDEAD_BEEF);
      step();
      bus.we = 1'b0; bus.ra1 = 5'd5;
      #1; check("array_rd0", bus.rd0, 32'hDEAD_BEEF);
      check("array_rd1", bus.rd1, 32'hDEAD_BEEF);

      // Address 21 differs from 5 only in bit 4.
      step();
      bus.we = 1'b1; bus.wa = 5'd21; bus.wd = 32'h1234_5678;
      step();
      bus.we = 1'b0; bus.ra_dbg = 5'd5;
      #1; check("addr_full_5", bus.rd_dbg, 32'hDEAD_BEEF);
      bus.ra_dbg = 5'd21;
      #1; check("addr_full_21", bus.rd_dbg, 32'h1234_5678);

      // Register 0 is hardwired.
      step();
      bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'h1234; bus.ra0 = 5'd0;
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
      #1; check("zero_rd0_same", bus.rd0, 32'h0);
      check("zero_busy_same", bus.busy0, 32'h0);
      step();
      bus.we = 1'b0; bus.issue_valid = 1'b0;
      #1; check("zero_rd0_next", bus.rd0, 32'h0);
      check("zero_busy_next", bus.busy0, 32'h0);

      // Issue sets busy one cycle later; writeback clears it combinationally.
      step();
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.ra1 = 5'd7;
      #1; check("iss7_same", bus.busy1, 32'h0);
      step();
      bus.issue_valid = 1'b0;
      #1; check("iss7_next", bus.busy1, 32'h1);
      repeat (2) step();
      #1; check("iss7_hold", bus.busy1, 32'h1);
      bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'h0BAD_F00D;
      #1; check("wb7_busy", bus.busy1, 32'h0);
      check("wb7_rd1", bus.rd1, 32'h0BAD_F00D);
      step();
      bus.we = 1'b0;
      #1; check("wb7_busy_next", bus.busy1, 32'h0);
      check("wb7_rd1_next", bus.rd1, 32'h0BAD_F00D);

      // Same-cycle set and clear: set wins.
      step();
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd9; bus.ra0 = 5'd9;
      step();
      bus.issue_valid = 1'b0;
      #1; check("p9_set", bus.busy0, 32'h1);
      step();
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
      bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'h0000_0099;
      #1; check("p9_both_rd0", bus.rd0, 32'h0000_0099);
      check("p9_both_busy", bus.busy0, 32'h0);
      step();
      bus.issue_valid = 1'b0; bus.we = 1'b0;
      #1; check("p9_set_wins", bus.busy0, 32'h1);
      check("p9_rd0", bus.rd0, 32'h0000_0099);
      step();
      bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'h0000_0100;
      step();
      bus.we = 1'b0;
      #1; check("p9_cleared", bus.busy0, 32'h0);
      check("p9_rd0_new", bus.rd0, 32'h0000_0100);

      // Reset mid-RUN.
      step();
      bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'hA5A5_A5A5;
      step();
      bus.we = 1'b0; bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
      step();
      bus.issue_valid = 1'b0; bus.ra0 = 5'd3;
      #1; check("pre_rst_busy", bus.busy0, 32'h1);
      check("pre_rst_rd0", bus.rd0, 32'hA5A5_A5A5);
      #1 rst = 1'b1;
      #1; check("rst_async_done", bus.init_done, 32'h0);
      check("rst_async_busy", bus.busy0, 32'h0);
      check("rst_async_rd0", bus.rd0, 32'h0);
      repeat (2) step();
      rst = 1'b0;
      wait_init("init2");
      step(); #1;
      check("reinit_rd0", bus.rd0, 32'h0);
      check("reinit_busy", bus.busy0, 32'h0);
      bus.ra_dbg = 5'd5;
      #1; check("reinit_dbg5", bus.rd_dbg, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
